// File: rtl/sig_divider_if.sv
// Purpose: start/done request bundle between an FPU divide sequencer and sig_divider.
// Ports: start/a/b flow from the requester; ready/done/quot/rem/div_by_zero come back from the divider.
// The master modport is the requester side and the slave modport is the divider side.
interface sig_divider_if #(
  parameter int WIDTH = 58
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  ready, done, quot, rem, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output ready, done, quot, rem, div_by_zero
  );
endinterface

// File: rtl/sig_divider.sv
// Purpose: iterative radix-2 restoring divider for unsigned significands (quot = a / b, rem = a % b).
// Latency: WIDTH cycles from the accepted start to done; 1 cycle when b == 0.
// Backpressure: start is only accepted while ready=1; starts in BUSY/DONE are dropped, so issue waits one idle cycle.
// Ports: clk, rst (async, active high), bus (slave side of sig_divider_if: start/a/b in, ready/done/quot/rem/div_by_zero out).
module sig_divider #(
  parameter int WIDTH = 58
) (
  input  logic         clk,
  input  logic         rst,
  sig_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  // The dividend register doubles as the quotient register: each iteration
  // shifts one dividend bit out of the MSB and one quotient bit into the LSB.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  // Shifted partial remainder, kept one bit wider than r so the borrow of the
  // trial subtraction is the comparison result. Since r < b holds after every
  // iteration, the top bits of t and of r are always zero.
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   r_nxt;
  logic             b_zero;
  logic             last;

  always_comb begin
    t      = {r, dvd[WIDTH-1]};
    diff   = t - {2'b00, dvs};
    ge     = ~diff[WIDTH+1];
    r_nxt  = ge ? diff[WIDTH:0] : t[WIDTH:0];
    b_zero = (dvs == '0);
    last   = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (b_zero || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      r      <= '0;
      count  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd   <= bus.a;
            dvs   <= bus.b;
            r     <= '0;
            count <= '0;
          end
        end
        BUSY: begin
          if (b_zero) begin
            // No iterations ran, so dvd still holds the captured dividend.
            quot_q <= '1;
            rem_q  <= dvd;
            dbz_q  <= 1'b1;
          end else begin
            dvd   <= {dvd[WIDTH-2:0], ge};
            r     <= r_nxt;
            count <= count + CW'(1);
            if (last) begin
              quot_q <= {dvd[WIDTH-2:0], ge};
              rem_q  <= r_nxt[WIDTH-1:0];
              dbz_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_sig_divider.sv
// Purpose: self-checking bench for sig_divider against a plain-arithmetic reference (a / b, a % b).
// Ports: none; drives the master side of sig_divider_if and clk/rst.
// Each scenario task does its own comparisons; one summary line is printed at the end.
module tb_sig_divider;
  localparam int WIDTH = 58;
  localparam int TMO   = 200;

  typedef logic [WIDTH-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sig_divider_if #(.WIDTH(WIDTH)) bus ();

  sig_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus only: waits for ready, issues one operation, then counts cycles
  // until done. mid_q/mid_r are the result outputs one cycle after the start
  // edge. lat is -1 if done never arrives.
  task automatic issue(input word_t a, input word_t b, output int lat,
                       output word_t mid_q, output word_t mid_r);
    int guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < TMO) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    mid_q = bus.quot;
    mid_r = bus.rem;
    lat = -1;
    for (int c = 1; c <= TMO && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) lat = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.quot !== '0) begin n_fail++; $display("FAIL reset_quot got %h want 0", bus.quot); end
    n_checks++; if (bus.rem !== '0) begin n_fail++; $display("FAIL reset_rem got %h want 0", bus.rem); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    word_t ta[4] = '{58'd12, 58'd100, 58'd2, 58'd0};
    word_t tb[4] = '{58'd12, 58'd7,   58'd1, 58'd12};
    word_t tq[4] = '{58'd1,  58'd14,  58'd2, 58'd0};
    word_t tr[4] = '{58'd0,  58'd2,   58'd0, 58'd0};
    int lat;
    word_t mq, mr;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], lat, mq, mr);
      n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL basic_lat[%0d] got %0d want %0d", i, lat, WIDTH); end
      n_checks++; if (bus.quot !== tq[i]) begin n_fail++; $display("FAIL basic_quot[%0d] got %0d want %0d", i, bus.quot, tq[i]); end
      n_checks++; if (bus.rem !== tr[i]) begin n_fail++; $display("FAIL basic_rem[%0d] got %0d want %0d", i, bus.rem, tr[i]); end
      n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz[%0d] got %b want 0", i, bus.div_by_zero); end
      // done is a single-cycle pulse and results stay put afterwards
      @(posedge clk); #1;
      n_checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin n_fail++; $display("FAIL basic_pulse[%0d] got done=%b ready=%b want done=0 ready=1", i, bus.done, bus.ready); end
      n_checks++; if (bus.quot !== tq[i]) begin n_fail++; $display("FAIL basic_hold[%0d] got %0d want %0d", i, bus.quot, tq[i]); end
    end
  endtask

  task automatic test_pattern();
    word_t a, b, eq, er;
    logic [2*WIDTH-1:0] recon;
    int lat;
    word_t mq, mr;
    a  = 58'h2AAAAAAAAAAAAAA;
    b  = 58'h3333;
    eq = a / b;
    er = a % b;
    issue(a, b, lat, mq, mr);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL pattern_lat got %0d want %0d", lat, WIDTH); end
    n_checks++; if (bus.quot !== eq) begin n_fail++; $display("FAIL pattern_quot got %h want %h", bus.quot, eq); end
    n_checks++; if (bus.rem !== er) begin n_fail++; $display("FAIL pattern_rem got %h want %h", bus.rem, er); end
    recon = {{WIDTH{1'b0}}, bus.quot} * {{WIDTH{1'b0}}, b} + {{WIDTH{1'b0}}, bus.rem};
    n_checks++; if (recon !== {{WIDTH{1'b0}}, a}) begin n_fail++; $display("FAIL pattern_recon got %h want %h", recon, a); end
  endtask

  task automatic test_div_zero();
    int lat;
    word_t mq, mr;
    word_t ones;
    ones = '1;
    issue(58'd144, 58'd0, lat, mq, mr);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_lat got %0d want 1", lat); end
    n_checks++; if (bus.quot !== ones) begin n_fail++; $display("FAIL dz_quot got %h want %h", bus.quot, ones); end
    n_checks++; if (bus.rem !== 58'd144) begin n_fail++; $display("FAIL dz_rem got %0d want 144", bus.rem); end
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", bus.div_by_zero); end
    @(posedge clk); #1;
    n_checks++; if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL dz_hold got dbz=%b done=%b want dbz=1 done=0", bus.div_by_zero, bus.done); end
    // A normal division clears the flag
    issue(58'd100, 58'd7, lat, mq, mr);
    n_checks++; if (mq !== ones || mr !== 58'd144) begin n_fail++; $display("FAIL dz_keep_on_start got %h/%0d want %h/144", mq, mr, ones); end
    n_checks++; if (bus.div_by_zero !== 1'b0 || bus.quot !== 58'd14 || bus.rem !== 58'd2) begin n_fail++; $display("FAIL dz_clear got dbz=%b q=%0d r=%0d want 0/14/2", bus.div_by_zero, bus.quot, bus.rem); end
  endtask

  task automatic test_start_ignored();
    int lat, ready_bad, guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < TMO) begin @(posedge clk); #1; guard++; end
    bus.a = 58'd144; bus.b = 58'd12; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    ready_bad = 0;
    for (int c = 1; c <= TMO && lat < 0; c++) begin
      if (c == 10) begin bus.a = 58'd5; bus.b = 58'd1; bus.start = 1'b1; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) lat = c;
      else if (bus.ready !== 1'b0) ready_bad++;
    end
    n_checks++; if (ready_bad !== 0) begin n_fail++; $display("FAIL busy_ready got %0d cycles with ready!=0 want 0", ready_bad); end
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL busy_lat got %0d want %0d", lat, WIDTH); end
    n_checks++; if (bus.quot !== 58'd12 || bus.rem !== 58'd0) begin n_fail++; $display("FAIL busy_result got q=%0d r=%0d want 12/0", bus.quot, bus.rem); end
    // start during the DONE cycle must not be accepted
    bus.a = 58'd5; bus.b = 58'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL done_start_ignored got ready=%b want 1", bus.ready); end
    n_checks++; if (bus.quot !== 58'd12) begin n_fail++; $display("FAIL done_start_quot got %0d want 12", bus.quot); end
  endtask

  task automatic test_reset_midflight();
    int lat, dones, guard;
    word_t mq, mr;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < TMO) begin @(posedge clk); #1; guard++; end
    bus.a = 58'd144; bus.b = 58'd12; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got ready=%b done=%b want 1/0", bus.ready, bus.done); end
    n_checks++; if (bus.quot !== '0 || bus.rem !== '0 || bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_data got q=%0d r=%0d dbz=%b want 0/0/0", bus.quot, bus.rem, bus.div_by_zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (WIDTH + 10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d pulses want 0", dones); end
    issue(58'd100, 58'd7, lat, mq, mr);
    n_checks++; if (lat !== WIDTH || bus.quot !== 58'd14 || bus.rem !== 58'd2) begin n_fail++; $display("FAIL midrst_after got lat=%0d q=%0d r=%0d want %0d/14/2", lat, bus.quot, bus.rem, WIDTH); end
  endtask

  // Randomised back-to-back issue: operands of mixed magnitude, zero divisors
  // included, checked against a / b and a % b. Also checks the previous
  // result is still on the outputs while the next operation is in flight.
  task automatic test_random();
    logic [63:0] w;
    word_t a, b, eq, er, pq, pr, mq, mr;
    int lat, elat;
    logic edz;
    pq = 58'd14;
    pr = 58'd2;
    for (int i = 0; i < 30; i++) begin
      w = {$urandom, $urandom};
      a = w[WIDTH-1:0];
      if ($urandom_range(0, 3) == 0) a = word_t'($urandom_range(0, 1000));
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = word_t'($urandom_range(1, 255));
        2:       begin w = {$urandom, $urandom}; b = word_t'(w[40:0]) | 58'd1; end
        default: begin w = {$urandom, $urandom}; b = w[WIDTH-1:0] | 58'd1; end
      endcase
      if (b == '0) begin eq = '1; er = a; edz = 1'b1; elat = 1; end
      else begin eq = a / b; er = a % b; edz = 1'b0; elat = WIDTH; end
      issue(a, b, lat, mq, mr);
      n_checks++; if (mq !== pq || mr !== pr) begin n_fail++; $display("FAIL rnd_hold[%0d] got %h/%h want %h/%h", i, mq, mr, pq, pr); end
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, elat); end
      n_checks++; if (bus.quot !== eq || bus.rem !== er || bus.div_by_zero !== edz) begin
        n_fail++;
        $display("FAIL rnd_result[%0d] a=%h b=%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", i, a, b, bus.quot, bus.rem, bus.div_by_zero, eq, er, edz);
      end
      pq = eq;
      pr = er;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_pattern();
    test_div_zero();
    test_start_ignored();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
